counter_sequencer: RTL and testbench

- Controller for the 16-bit enable counter (ports clock, reset, E, Q).
- Generates a prescaled enable pulse train (E) and clear pulses (the counter's reset input) so the counter runs from 0 to a programmed limit.
- Supports start, pause/resume and clear commands.
- Checks the counter's Q against a shadow count and flags a fault on mismatch. Sits between board switches/keys and the counter.

---
 rtl/counter_sequencer.sv | 136 +++++++++++++
 tb/tb_counter_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Controller for a 16-bit enable counter: issues prescaled enable pulses and clear
// pulses so the counter runs 0..limit, and cross-checks its Q against a shadow count.
module counter_sequencer #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r, state_n;
    logic [DIV_W-1:0] presc_r, presc_n;
    logic [DIV_W-1:0] div_l, div_n;
    logic [WIDTH-1:0] issued_r, issued_n;
    logic [WIDTH-1:0] limit_l, limit_n;
    logic [WIDTH-1:0] expected;
    logic             en_n, clr_n, done_n, fault_n;
    logic             first_cycle, checking, mismatch, at_limit;

    // The counter is still being cleared in the first RUN cycle, so its Q is not yet meaningful.
    assign first_cycle = (state_r == RUN) && cnt_clr;
    assign checking    = (state_r != IDLE) && !first_cycle;
    assign expected    = issued_r - WIDTH'(cnt_en);
    assign mismatch    = checking && (cnt_q != expected);
    assign at_limit    = (issued_r == limit_l);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_n  = state_r;
        presc_n  = presc_r;
        div_n    = div_l;
        issued_n = issued_r;
        limit_n  = limit_l;
        en_n     = 1'b0;
        clr_n    = 1'b0;
        done_n   = done;
        fault_n  = fault;

        if (clear) begin
            state_n  = IDLE;
            clr_n    = 1'b1;
            done_n   = 1'b0;
            fault_n  = 1'b0;
            presc_n  = '0;
            issued_n = '0;
        end else if (mismatch) begin
            fault_n = 1'b1;
            state_n = IDLE;
        end else begin
            unique case (state_r)
                RUN: begin
                    if (stop) begin
                        state_n = PAUSE;
                    end else if (!first_cycle && at_limit && (cnt_q == limit_l)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (issued_r < limit_l) begin
                        if (presc_r == div_l) begin
                            en_n     = 1'b1;
                            issued_n = issued_r + WIDTH'(1);
                            presc_n  = '0;
                        end else begin
                            presc_n = presc_r + DIV_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    // IDLE and DONE: a fresh start clears the counter and relatches settings.
                    if (!stop && start) begin
                        state_n  = RUN;
                        div_n    = div;
                        limit_n  = limit;
                        clr_n    = 1'b1;
                        done_n   = 1'b0;
                        fault_n  = 1'b0;
                        presc_n  = '0;
                        issued_n = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_r  <= IDLE;
            presc_r  <= '0;
            div_l    <= '0;
            issued_r <= '0;
            limit_l  <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_r  <= state_n;
            presc_r  <= presc_n;
            div_l    <= div_n;
            issued_r <= issued_n;
            limit_l  <= limit_n;
            cnt_en   <= en_n;
            cnt_clr  <= clr_n;
            done     <= done_n;
            fault    <= fault_n;
        end
    end

    assign state = state_r;
    assign busy  = (state_r == RUN) || (state_r == PAUSE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: emulates the external counter and compares
// every cycle against a cycle-level behavioural model, plus directed literal checks.
module tb_counter_sequencer;

    localparam int WIDTH = 16;
    localparam int DIV_W = 8;

    logic             clock = 1'b0;
    logic             reset, start, stop, clear;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] limit, cnt_q;
    logic             cnt_en, cnt_clr, busy, done, fault;
    logic [1:0]       state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // counter emulation controls
    bit stuck  = 1'b0;
    bit glitch = 1'b0;

    // behavioural model: mode 0=IDLE 1=RUN 2=PAUSE 3=DONE
    int m_mode, m_div, m_lim, m_prior, m_active;
    bit m_en, m_clr, m_done, m_fault;

    // watch-window results
    int w_en_n, w_en_first, w_en_last, w_clr_n, w_done_at;

    always #5 clock = ~clock;

    counter_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .div    (div),
        .limit  (limit),
        .cnt_q  (cnt_q),
        .cnt_en (cnt_en),
        .cnt_clr(cnt_clr),
        .busy   (busy),
        .done   (done),
        .fault  (fault),
        .state  (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_div = 0; m_lim = 0; m_prior = 0; m_active = 0;
        m_en = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_fault = 1'b0;
    endtask

    // Advances the model by one clock using the inputs and counter Q of the current cycle.
    // m_prior = enable pulses strictly before the current cycle; m_active = RUN cycles
    // spent counting since the last start/clear (pulse due whenever it hits a multiple of div+1).
    task automatic model_step();
        int tot;
        bit first, mism, n_en, n_clr;
        if (reset) begin
            model_reset();
            return;
        end
        tot   = m_prior + int'(m_en);
        first = (m_mode == 1) && m_clr;
        mism  = (m_mode != 0) && !first && (int'(cnt_q) != m_prior);
        n_en  = 1'b0;
        n_clr = 1'b0;
        if (clear) begin
            m_mode = 0; n_clr = 1'b1; m_done = 1'b0; m_fault = 1'b0; m_active = 0; tot = 0;
        end else if (mism) begin
            m_fault = 1'b1; m_mode = 0;
        end else begin
            case (m_mode)
                1: begin
                    if (stop) m_mode = 2;
                    else if (!first && tot == m_lim && int'(cnt_q) == m_lim) begin
                        m_mode = 3; m_done = 1'b1;
                    end else if (tot < m_lim) begin
                        m_active++;
                        if (m_active % (m_div + 1) == 0) n_en = 1'b1;
                    end
                end
                2: if (!stop && start) m_mode = 1;
                default: if (!stop && start) begin
                    m_div = int'(div); m_lim = int'(limit); m_mode = 1; n_clr = 1'b1;
                    m_done = 1'b0; m_fault = 1'b0; m_active = 0; tot = 0;
                end
            endcase
        end
        m_prior = tot;
        m_en    = n_en;
        m_clr   = n_clr;
    endtask

    // One clock: emulate the counter, step the model, then compare #1 after the edge.
    task automatic tick();
        logic [WIDTH-1:0] q_nxt;
        if (cnt_clr === 1'b1)     q_nxt = '0;
        else if (cnt_en === 1'b1) q_nxt = cnt_q + 16'd1;
        else                      q_nxt = cnt_q;
        if (stuck)  q_nxt = '0;
        if (glitch) q_nxt = q_nxt + 16'd1;
        model_step();
        @(posedge clock);
        #1;
        cnt_q = q_nxt;
        cyc++;
        check("cnt_en",  32'(cnt_en),  32'(m_en));
        check("cnt_clr", 32'(cnt_clr), 32'(m_clr));
        check("busy",    32'(busy),    32'((m_mode == 1) || (m_mode == 2)));
        check("done",    32'(done),    32'(m_done));
        check("fault",   32'(fault),   32'(m_fault));
        check("state",   32'(state),   32'(m_mode));
    endtask

    task automatic watch(input int n);
        w_en_n = 0; w_en_first = -1; w_en_last = -1; w_clr_n = 0; w_done_at = -1;
        repeat (n) begin
            tick();
            if (cnt_en === 1'b1) begin
                if (w_en_n == 0) w_en_first = cyc;
                w_en_last = cyc;
                w_en_n++;
            end
            if (cnt_clr === 1'b1) w_clr_n++;
            if (done === 1'b1 && w_done_at < 0) w_done_at = cyc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, n, r1;
        model_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
        div = '0; limit = '0; cnt_q = '0;

        // reset held two cycles with start high
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_outs", 32'({cnt_en, cnt_clr, busy, done, fault}), 0);
        tick();
        check("rst_state2", 32'(state), 0);
        reset = 1'b0;
        tick();
        check("post_rst_run", 32'(state), 1);
        check("post_rst_clr", 32'(cnt_clr), 1);
        start = 1'b0;
        watch(4);

        // div=0, limit=3
        div = 8'd0; limit = 16'd3; start = 1'b1;
        tick(); start = 1'b0; c = cyc;
        check("t2_clr_at_c", 32'(cnt_clr), 1);
        watch(8);
        check("t2_en_count", w_en_n, 3);
        check("t2_en_first", w_en_first, c + 1);
        check("t2_en_last",  w_en_last,  c + 3);
        check("t2_clr_count", w_clr_n, 0);
        check("t2_done_at", w_done_at, c + 5);
        check("t2_state_done", 32'(state), 3);
        check("t2_busy", 32'(busy), 0);
        check("t2_q", 32'(cnt_q), 3);

        // div=2, limit=2, inputs changed mid-run
        div = 8'd2; limit = 16'd2; start = 1'b1;
        tick(); start = 1'b0; c = cyc;
        div = 8'd0; limit = 16'd7;
        watch(12);
        check("t3_en_count", w_en_n, 2);
        check("t3_en_first", w_en_first, c + 3);
        check("t3_en_last",  w_en_last,  c + 6);
        check("t3_done_at", w_done_at, c + 8);

        // div=1, limit=10 with pause/resume
        div = 8'd1; limit = 16'd10; start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            tick();
            if (cnt_en === 1'b1) n++;
        end
        check("t4_pulses_before_stop", n, 3);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_paused", 32'(state), 2);
        watch(20);
        check("t4_pause_en", w_en_n, 0);
        check("t4_pause_state", 32'(state), 2);
        check("t4_hold_q", 32'(cnt_q), 3);
        start = 1'b1; tick(); start = 1'b0; r1 = cyc;
        watch(30);
        check("t4_resume_phase", w_en_first, r1 + 2);
        check("t4_resume_pulses", w_en_n, 7);
        check("t4_resume_noclr", w_clr_n, 0);
        check("t4_final_q", 32'(cnt_q), 10);
        check("t4_done", 32'(done), 1);

        // clear beats stop and start; then limit=0
        div = 8'd0; limit = 16'd9; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 30 && cnt_q != 16'd5; i++) tick();
        check("t5_q_reached", 32'(cnt_q), 5);
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        check("t5_clr_state", 32'(state), 0);
        check("t5_clr_pulse", 32'(cnt_clr), 1);
        check("t5_clr_done", 32'(done), 0);
        tick();
        check("t5_clr_single", 32'(cnt_clr), 0);
        check("t5_q_cleared", 32'(cnt_q), 0);
        div = 8'd3; limit = 16'd0; start = 1'b1;
        tick(); start = 1'b0; c = cyc;
        watch(6);
        check("t5_lim0_en", w_en_n, 0);
        check("t5_lim0_done_at", w_done_at, c + 2);

        // counter stuck at 0 after the first pulse
        div = 8'd0; limit = 16'd5; start = 1'b1;
        tick(); start = 1'b0; c = cyc;
        tick();
        check("t6_first_pulse", 32'(cnt_en), 1);
        stuck = 1'b1;
        tick();
        tick();
        check("t6_fault_at", 32'(fault), 1);
        check("t6_fault_state", 32'(state), 0);
        check("t6_fault_en", 32'(cnt_en), 0);
        watch(5);
        check("t6_fault_sticky", 32'(fault), 1);
        check("t6_fault_no_en", w_en_n, 0);
        stuck = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        check("t6_start_clears", 32'(fault), 0);
        watch(12);
        check("t6_recovered_done", 32'(done), 1);
        check("t6_recovered_q", 32'(cnt_q), 5);

        // randomized operation, including occasional resets and counter glitches
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 24) == 0);
            stop   = ($urandom_range(0, 49) == 0);
            clear  = ($urandom_range(0, 149) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            glitch = ($urandom_range(0, 299) == 0);
            div    = DIV_W'($urandom_range(0, 3));
            limit  = WIDTH'($urandom_range(0, 12));
            tick();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; glitch = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
